pc_flow_controller: RTL and testbench
=====================================

Name: pc_flow_controller

Overview:
- Central fetch-flow controller for the pipelined RV32 core with attached MMM (matrix-multiply) unit.
- Arbitrates redirect, hazard-stall and MMM-stall sources, then drives the PC's jump_addr, pc_sel, stall and mmm_stall inputs plus the IF/ID and ID/EX hold/flush controls.
- Sequences the MMM start/done handshake with a timeout watchdog and keeps freeze and redirect performance counters.

Parameters:
XLEN, 32, address/data width
MMM_TIMEOUT, 1024, maximum MMM_WAIT cycles before abort
CNT_W, 32, width of performance counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ex_redirect  input  1  branch/JALR in EX resolved taken (mispredict)
ex_target  input  XLEN  redirect target from EX
id_jump  input  1  JAL decoded in ID
id_target  input  XLEN  JAL target from ID
load_use_hazard  input  1  ID consumes the destination of a load in EX
mmm_req  input  1  MMM instruction valid in ID
mmm_done  input  1  MMM unit completion pulse
jump_addr  output  XLEN  PC load value
pc_sel  output  1  PC load enable
stall  output  1  PC hold (pipeline hazard)
mmm_stall  output  1  PC hold (MMM)
if_id_hold  output  1  IF/ID register hold
if_id_flush  output  1  IF/ID register clear
id_ex_flush  output  1  inject bubble into ID/EX
mmm_start  output  1  one-cycle MMM start pulse
mmm_error  output  1  sticky timeout flag
freeze_count  output  CNT_W  cycles with PC frozen
redirect_count  output  CNT_W  cycles with pc_sel=1

Behaviour:
- PC hold rule: the PC advances unless stall AND mmm_stall are both 1. A "freeze" is therefore defined as stall=mmm_stall=if_id_hold=1. The block never asserts only one of stall/mmm_stall.
- States: RUN, MMM_ISSUE, MMM_WAIT, MMM_RELEASE. Reset state is RUN.
- Reset: while reset=1, all control outputs are 0. Counters and mmm_error clear to 0 and the state returns to RUN, including from mid-MMM_WAIT.
- RUN priority, combinational, same cycle (highest first):
  1. ex_redirect: pc_sel=1, jump_addr=ex_target, if_id_flush=1, id_ex_flush=1. mmm_req, load_use_hazard and id_jump are ignored that cycle (wrong path).
  2. mmm_req: freeze and id_ex_flush=1; next state MMM_ISSUE.
  3. load_use_hazard: freeze and id_ex_flush=1 for that cycle only; remain in RUN.
  4. id_jump: pc_sel=1, jump_addr=id_target, if_id_flush=1; no id_ex_flush.
  5. Otherwise all controls are 0.
- jump_addr=0 whenever pc_sel=0.
- MMM_ISSUE: freeze, id_ex_flush=1, mmm_start=1 (exactly one cycle); next state MMM_WAIT with the timeout counter cleared.
- MMM_WAIT:
  - freeze and id_ex_flush=1; timeout counter increments each cycle.
  - mmm_done → MMM_RELEASE.
  - Counter reaching MMM_TIMEOUT-1 without done → mmm_error=1 (sticky) and MMM_RELEASE.
  - ex_redirect, load_use_hazard and id_jump are ignored (EX holds only bubbles).
- mmm_done in any state other than MMM_WAIT is ignored.
- MMM_RELEASE: all controls 0 and mmm_req ignored, so the MMM instruction advances to EX without retriggering; next state RUN.
- MMM latency: entering cycle T (RUN with mmm_req) → mmm_start at T+1. Done at cycle D → release at D+1, RUN at D+2.
- Counters:
  - freeze_count +1 every cycle freeze is asserted.
  - redirect_count +1 every cycle pc_sel=1.
  - Both saturate at all-ones; no wrap.

Test Plan:
- Reset mid-operation: enter MMM_WAIT, assert reset one cycle → all outputs 0, state RUN, counters 0, no mmm_start on release.
- Redirect plus MMM same cycle: ex_redirect=1, ex_target=0x100, mmm_req=1, load_use_hazard=1 → pc_sel=1, jump_addr=0x100, both flushes high, no freeze, no mmm_start next cycle.
- Load-use then jump: load_use_hazard one cycle with id_jump=1 (id_target=0x40) → freeze plus bubble, pc_sel=0. Next cycle (hazard clear) → pc_sel=1, jump_addr=0x40, if_id_flush=1, id_ex_flush=0.
- MMM handshake: mmm_req at T, mmm_done at T+10 → mmm_start only at T+1; freeze T..T+10; all controls 0 at T+11 even with mmm_req=1; freeze_count=11.
- Timeout: MMM_TIMEOUT=8, never assert done → mmm_error=1 after 8 WAIT cycles, release, return to RUN; mmm_error stays 1 until reset.
- Saturation: CNT_W=4, 20 redirect cycles → redirect_count=15.

Source files
------------

// File: rtl/pc_flow_controller_if.sv
// Fetch-flow control bundle between the core pipeline (master) and the
// pc_flow_controller (slave): redirect/hazard/MMM requests in, PC and pipeline controls out.
interface pc_flow_controller_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic            ex_redirect;
  logic [XLEN-1:0] ex_target;
  logic            id_jump;
  logic [XLEN-1:0] id_target;
  logic            load_use_hazard;
  logic            mmm_req;
  logic            mmm_done;

  logic [XLEN-1:0] jump_addr;
  logic            pc_sel;
  logic            stall;
  logic            mmm_stall;
  logic            if_id_hold;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            mmm_start;
  logic            mmm_error;
  logic [CNT_W-1:0] freeze_count;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output ex_redirect, ex_target, id_jump, id_target,
           load_use_hazard, mmm_req, mmm_done,
    input  jump_addr, pc_sel, stall, mmm_stall, if_id_hold, if_id_flush,
           id_ex_flush, mmm_start, mmm_error, freeze_count, redirect_count
  );

  modport slave (
    input  ex_redirect, ex_target, id_jump, id_target,
           load_use_hazard, mmm_req, mmm_done,
    output jump_addr, pc_sel, stall, mmm_stall, if_id_hold, if_id_flush,
           id_ex_flush, mmm_start, mmm_error, freeze_count, redirect_count
  );
endinterface

// File: rtl/pc_flow_controller.sv
// Central fetch-flow controller: arbitrates redirects, hazard stalls and the MMM
// start/done handshake (with timeout watchdog) and counts freeze/redirect cycles.
module pc_flow_controller #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MMM_TIMEOUT = 1024,
  parameter int unsigned CNT_W       = 32
) (
  input  logic clk,
  input  logic reset,
  pc_flow_controller_if.slave bus
);

  localparam logic [1:0] RUN         = 2'd0;
  localparam logic [1:0] MMM_ISSUE   = 2'd1;
  localparam logic [1:0] MMM_WAIT    = 2'd2;
  localparam logic [1:0] MMM_RELEASE = 2'd3;

  localparam int unsigned     TO_W    = (MMM_TIMEOUT > 1) ? $clog2(MMM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MMM_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             mmm_error_q, mmm_error_d;
  logic [CNT_W-1:0] freeze_count_q, freeze_count_d;
  logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

  logic            pc_sel_c;
  logic [XLEN-1:0] jump_addr_c;
  logic            freeze_c;
  logic            if_id_flush_c;
  logic            id_ex_flush_c;
  logic            mmm_start_c;

  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    mmm_error_d   = mmm_error_q;
    pc_sel_c      = 1'b0;
    jump_addr_c   = '0;
    freeze_c      = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    mmm_start_c   = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.ex_redirect) begin
          pc_sel_c      = 1'b1;
          jump_addr_c   = bus.ex_target;
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (bus.mmm_req) begin
          freeze_c      = 1'b1;
          id_ex_flush_c = 1'b1;
          state_d       = MMM_ISSUE;
        end else if (bus.load_use_hazard) begin
          freeze_c      = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (bus.id_jump) begin
          pc_sel_c      = 1'b1;
          jump_addr_c   = bus.id_target;
          if_id_flush_c = 1'b1;
        end
      end
      MMM_ISSUE: begin
        freeze_c      = 1'b1;
        id_ex_flush_c = 1'b1;
        mmm_start_c   = 1'b1;
        to_cnt_d      = '0;
        state_d       = MMM_WAIT;
      end
      MMM_WAIT: begin
        // EX holds only bubbles here, so redirect/hazard/jump inputs are not consulted.
        freeze_c      = 1'b1;
        id_ex_flush_c = 1'b1;
        to_cnt_d      = to_cnt_q + 1'b1;
        if (bus.mmm_done) begin
          state_d = MMM_RELEASE;
        end else if (to_cnt_q == TO_LAST) begin
          mmm_error_d = 1'b1;
          state_d     = MMM_RELEASE;
        end
      end
      MMM_RELEASE: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // State may still be mid-handshake during the reset cycle; keep controls quiet.
    if (reset) begin
      pc_sel_c      = 1'b0;
      jump_addr_c   = '0;
      freeze_c      = 1'b0;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
      mmm_start_c   = 1'b0;
    end

    freeze_count_d = freeze_count_q;
    if (freeze_c && (freeze_count_q != '1)) begin
      freeze_count_d = freeze_count_q + 1'b1;
    end
    redirect_count_d = redirect_count_q;
    if (pc_sel_c && (redirect_count_q != '1)) begin
      redirect_count_d = redirect_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= RUN;
      to_cnt_q         <= '0;
      mmm_error_q      <= 1'b0;
      freeze_count_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      to_cnt_q         <= to_cnt_d;
      mmm_error_q      <= mmm_error_d;
      freeze_count_q   <= freeze_count_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign bus.jump_addr      = jump_addr_c;
  assign bus.pc_sel         = pc_sel_c;
  assign bus.stall          = freeze_c;
  assign bus.mmm_stall      = freeze_c;
  assign bus.if_id_hold     = freeze_c;
  assign bus.if_id_flush    = if_id_flush_c;
  assign bus.id_ex_flush    = id_ex_flush_c;
  assign bus.mmm_start      = mmm_start_c;
  assign bus.mmm_error      = mmm_error_q;
  assign bus.freeze_count   = freeze_count_q;
  assign bus.redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pc_flow_controller.sv
// Directed bench: dut_a uses default parameters, dut_b uses MMM_TIMEOUT=8 / CNT_W=4
// for the timeout and counter-saturation scenarios; both see the same stimulus.
module tb_pc_flow_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        id_jump;
  logic [31:0] id_target;
  logic        load_use_hazard;
  logic        mmm_req;
  logic        mmm_done;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pc_flow_controller_if #(.XLEN(32), .CNT_W(32)) bus_a ();
  pc_flow_controller_if #(.XLEN(32), .CNT_W(4))  bus_b ();

  assign bus_a.ex_redirect     = ex_redirect;
  assign bus_a.ex_target       = ex_target;
  assign bus_a.id_jump         = id_jump;
  assign bus_a.id_target       = id_target;
  assign bus_a.load_use_hazard = load_use_hazard;
  assign bus_a.mmm_req         = mmm_req;
  assign bus_a.mmm_done        = mmm_done;
  assign bus_b.ex_redirect     = ex_redirect;
  assign bus_b.ex_target       = ex_target;
  assign bus_b.id_jump         = id_jump;
  assign bus_b.id_target       = id_target;
  assign bus_b.load_use_hazard = load_use_hazard;
  assign bus_b.mmm_req         = mmm_req;
  assign bus_b.mmm_done        = mmm_done;

  pc_flow_controller #(.XLEN(32), .MMM_TIMEOUT(1024), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  pc_flow_controller #(.XLEN(32), .MMM_TIMEOUT(8), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // {pc_sel, stall, mmm_stall, if_id_hold, if_id_flush, id_ex_flush, mmm_start}
  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {bus_a.pc_sel, bus_a.stall, bus_a.mmm_stall, bus_a.if_id_hold,
                  bus_a.if_id_flush, bus_a.id_ex_flush, bus_a.mmm_start};
  assign ctl_b = {bus_b.pc_sel, bus_b.stall, bus_b.mmm_stall, bus_b.if_id_hold,
                  bus_b.if_id_flush, bus_b.id_ex_flush, bus_b.mmm_start};

  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_REDIR  = 7'b1000110;
  localparam logic [6:0] C_JUMP   = 7'b1000100;
  localparam logic [6:0] C_FREEZE = 7'b0111010;
  localparam logic [6:0] C_ISSUE  = 7'b0111011;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_redirect = 1'b0; ex_target = '0; id_jump = 1'b0; id_target = '0;
    load_use_hazard = 1'b0; mmm_req = 1'b0; mmm_done = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    ex_redirect = 1'b1; ex_target = 32'h200; mmm_req = 1'b1;
    #1;
    checks++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL reset_ctl: got %b expected %b", ctl_a, C_IDLE); end
    checks++;
    if (bus_a.jump_addr !== 32'h0) begin fails++; $display("FAIL reset_jaddr: got %h expected 0", bus_a.jump_addr); end
    tick();
    tick();
    checks++;
    if ({bus_a.freeze_count, bus_a.redirect_count, bus_a.mmm_error} !== 65'h0) begin
      fails++; $display("FAIL reset_cnt: got %0d/%0d/%b expected 0/0/0",
                        bus_a.freeze_count, bus_a.redirect_count, bus_a.mmm_error);
    end
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mmm_req = 1'b1;
    tick();
    mmm_req = 1'b0;
    #1;
    checks++;
    if (ctl_a !== C_ISSUE) begin fails++; $display("FAIL midrst_issue: got %b expected %b", ctl_a, C_ISSUE); end
    tick();
    tick();
    checks++;
    if (ctl_a !== C_FREEZE) begin fails++; $display("FAIL midrst_wait: got %b expected %b", ctl_a, C_FREEZE); end
    reset = 1'b1;
    #1;
    checks++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL midrst_during: got %b expected %b", ctl_a, C_IDLE); end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL midrst_after: got %b expected %b", ctl_a, C_IDLE); end
    checks++;
    if (bus_a.freeze_count !== 32'd0) begin fails++; $display("FAIL midrst_fcnt: got %0d expected 0", bus_a.freeze_count); end
    mmm_done = 1'b1;
    tick();
    mmm_done = 1'b0;
    #1;
    checks++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL midrst_nostart: got %b expected %b", ctl_a, C_IDLE); end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    ex_redirect = 1'b1; ex_target = 32'h100; mmm_req = 1'b1; load_use_hazard = 1'b1;
    id_jump = 1'b1; id_target = 32'h40;
    #1;
    checks++;
    if (ctl_a !== C_REDIR) begin fails++; $display("FAIL redir_ctl: got %b expected %b", ctl_a, C_REDIR); end
    checks++;
    if (bus_a.jump_addr !== 32'h100) begin fails++; $display("FAIL redir_addr: got %h expected 00000100", bus_a.jump_addr); end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL redir_next: got %b expected %b", ctl_a, C_IDLE); end
    checks++;
    if (bus_a.redirect_count !== 32'd1) begin fails++; $display("FAIL redir_cnt: got %0d expected 1", bus_a.redirect_count); end
  endtask

  task automatic test_load_use_jump();
    do_reset();
    load_use_hazard = 1'b1; id_jump = 1'b1; id_target = 32'h40;
    #1;
    checks++;
    if (ctl_a !== C_FREEZE) begin fails++; $display("FAIL lu_ctl: got %b expected %b", ctl_a, C_FREEZE); end
    checks++;
    if (bus_a.jump_addr !== 32'h0) begin fails++; $display("FAIL lu_addr: got %h expected 0", bus_a.jump_addr); end
    tick();
    load_use_hazard = 1'b0;
    #1;
    checks++;
    if (ctl_a !== C_JUMP) begin fails++; $display("FAIL jmp_ctl: got %b expected %b", ctl_a, C_JUMP); end
    checks++;
    if (bus_a.jump_addr !== 32'h40) begin fails++; $display("FAIL jmp_addr: got %h expected 00000040", bus_a.jump_addr); end
    tick();
    id_jump = 1'b0;
    #1;
    checks++;
    if ({bus_a.freeze_count, bus_a.redirect_count} !== {32'd1, 32'd1}) begin
      fails++; $display("FAIL lu_cnts: got %0d/%0d expected 1/1", bus_a.freeze_count, bus_a.redirect_count);
    end
  endtask

  task automatic test_mmm_handshake();
    do_reset();
    mmm_req = 1'b1;
    #1;
    checks++;
    if (ctl_a !== C_FREEZE) begin fails++; $display("FAIL mmm_t0: got %b expected %b", ctl_a, C_FREEZE); end
    for (int c = 1; c <= 10; c++) begin
      tick();
      mmm_done = (c == 10);
      #1;
      checks++;
      if (ctl_a !== ((c == 1) ? C_ISSUE : C_FREEZE)) begin
        fails++; $display("FAIL mmm_t%0d: got %b expected %b", c, ctl_a, (c == 1) ? C_ISSUE : C_FREEZE);
      end
    end
    tick();
    mmm_done = 1'b0;
    #1;
    checks++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL mmm_release: got %b expected %b", ctl_a, C_IDLE); end
    checks++;
    if (bus_a.freeze_count !== 32'd11) begin fails++; $display("FAIL mmm_fcnt: got %0d expected 11", bus_a.freeze_count); end
    tick();
    mmm_req = 1'b0;
    mmm_done = 1'b1;
    #1;
    checks++;
    if ({ctl_a, bus_a.mmm_error} !== {C_IDLE, 1'b0}) begin
      fails++; $display("FAIL mmm_run: got %b/%b expected %b/0", ctl_a, bus_a.mmm_error, C_IDLE);
    end
    tick();
    mmm_done = 1'b0;
    #1;
    checks++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL mmm_stray_done: got %b expected %b", ctl_a, C_IDLE); end
  endtask

  task automatic test_timeout();
    do_reset();
    mmm_req = 1'b1;
    tick();
    mmm_req = 1'b0;
    #1;
    checks++;
    if (ctl_b !== C_ISSUE) begin fails++; $display("FAIL to_issue: got %b expected %b", ctl_b, C_ISSUE); end
    for (int w = 1; w <= 8; w++) begin
      tick();
      checks++;
      if ({ctl_b, bus_b.mmm_error} !== {C_FREEZE, 1'b0}) begin
        fails++; $display("FAIL to_wait%0d: got %b/%b expected %b/0", w, ctl_b, bus_b.mmm_error, C_FREEZE);
      end
    end
    tick();
    checks++;
    if ({ctl_b, bus_b.mmm_error} !== {C_IDLE, 1'b1}) begin
      fails++; $display("FAIL to_release: got %b/%b expected %b/1", ctl_b, bus_b.mmm_error, C_IDLE);
    end
    load_use_hazard = 1'b1;
    tick();
    load_use_hazard = 1'b0;
    #1;
    checks++;
    if ({ctl_b, bus_b.mmm_error} !== {C_IDLE, 1'b1}) begin
      fails++; $display("FAIL to_sticky: got %b/%b expected %b/1", ctl_b, bus_b.mmm_error, C_IDLE);
    end
    do_reset();
    checks++;
    if (bus_b.mmm_error !== 1'b0) begin fails++; $display("FAIL to_clear: got %b expected 0", bus_b.mmm_error); end
  endtask

  task automatic test_saturation();
    do_reset();
    id_jump = 1'b1; id_target = 32'h80;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (bus_b.redirect_count !== 4'((i < 15) ? i : 15)) begin
        fails++; $display("FAIL sat_cnt%0d: got %0d expected %0d", i, bus_b.redirect_count, (i < 15) ? i : 15);
      end
    end
    id_jump = 1'b0;
    #1;
    checks++;
    if (bus_a.redirect_count !== 32'd20) begin fails++; $display("FAIL sat_wide: got %0d expected 20", bus_a.redirect_count); end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_reset_mid_wait();
    test_redirect_priority();
    test_load_use_jump();
    test_mmm_handshake();
    test_timeout();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
